// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared defaults, slice-width helper and stage payload type for pipe_adder_n
package pipe_adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction
  typedef struct packed {
    logic valid;
    logic carry;
    logic [DEF_WIDTH-1:0] x;
    logic [DEF_WIDTH-1:0] y;
    logic [DEF_WIDTH-1:0] sum;
    logic sub;
  } payload_t;
endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage: one registered CHUNK-wide slice adder (slice K); ports clk, rst, hold, prev_* payload in, valid/carry/x/y/sum payload out
module pipe_adder_stage #(
  parameter int W = 16,
  parameter int C = 4,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         prev_valid,
  input  logic         prev_carry,
  input  logic [W-1:0] prev_x,
  input  logic [W-1:0] prev_y,
  input  logic [W-1:0] prev_sum,
  output logic         valid,
  output logic         carry,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] sum
);
  logic [C:0] r;
  assign r = {1'b0, prev_x[K*C +: C]} + {1'b0, prev_y[K*C +: C]} + {{C{1'b0}}, prev_carry};
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      carry <= 1'b0;
      x <= '0;
      y <= '0;
      sum <= '0;
    end else if (!hold) begin
      valid <= prev_valid;
      if (prev_valid) begin
        carry <= r[C];
        x <= prev_x;
        y <= prev_y;
        sum <= prev_sum | (W'(r[C-1:0]) << (K * C));
      end
    end
endmodule

// File: rtl/pipe_adder_n.sv
// pipe_adder_n: pipelined slice-carry adder with valid/ready (clk, rst, in_valid/in_ready, x, y, cin, [sub with PIPE_ADDER_SUB_EN], out_valid/out_ready, sum, cout, ovf)
module pipe_adder_n import pipe_adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  logic hold;
  logic v [STAGES+1];
  logic c [STAGES+1];
  logic [WIDTH-1:0] xs [STAGES+1];
  logic [WIDTH-1:0] ys [STAGES+1];
  logic [WIDTH-1:0] ss [STAGES+1];
  assign hold = out_valid && !out_ready;
  assign in_ready = !hold;
  assign v[0] = in_valid;
  assign xs[0] = x;
  assign ss[0] = '0;
`ifdef PIPE_ADDER_SUB_EN
  assign ys[0] = sub ? ~y : y;
  assign c[0] = sub | cin;
`else
  assign ys[0] = y;
  assign c[0] = cin;
`endif
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(.W(WIDTH), .C(CHUNK), .K(k)) u_stage (
      .clk(clk),
      .rst(rst),
      .hold(hold),
      .prev_valid(v[k]),
      .prev_carry(c[k]),
      .prev_x(xs[k]),
      .prev_y(ys[k]),
      .prev_sum(ss[k]),
      .valid(v[k+1]),
      .carry(c[k+1]),
      .x(xs[k+1]),
      .y(ys[k+1]),
      .sum(ss[k+1])
    );
  end
  assign out_valid = v[STAGES];
  assign sum = ss[STAGES];
  assign cout = c[STAGES];
  assign ovf = (xs[STAGES][WIDTH-1] == ys[STAGES][WIDTH-1]) && (ss[STAGES][WIDTH-1] != xs[STAGES][WIDTH-1]);
endmodule

// File: doc/pipe_adder_n.md
# pipe_adder_n

Parametrised, pipelined ripple-carry adder with a valid/ready handshake. Successor to the team's fixed 8-bit combinational full-adder chain. The WIDTH-bit addition is split into STAGES equal slices. Each slice is added in its own registered stage, and the carry is passed stage to stage, so operating frequency is decoupled from operand width. It sits between operand producers and result consumers in the datapath. Backpressure propagates through the block.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline stages (1..WIDTH); slice width CHUNK = WIDTH/STAGES.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- sub  input  1  subtract select; present only with PIPE_ADDER_SUB_EN.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement signed overflow.

## Operation
- A beat is accepted when in_valid && in_ready. A result is delivered when out_valid && out_ready.
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of x and y plus the carry registered by stage k-1. Stage 0 uses cin.
- Operand slices not yet consumed travel forward in per-stage skew registers. Completed sum slices travel forward alongside them.
- Each stage holds a valid bit. The pipeline is in-order; no reordering or dropping.
- Global stall: stall = out_valid && !out_ready. When stall is high, every stage register holds its value.
- in_ready = !stall. A bubble in the pipeline is filled only when the whole pipe advances.
- cout is the carry out of the last stage.
- ovf = (x[MSB] == y'[MSB]) && (sum[MSB] != x[MSB]), where y' is the effective B operand.
- Arithmetic is modulo 2^WIDTH. No saturation.
- While out_valid is low, sum/cout/ovf hold their last values. Consumers must ignore them.

## Timing
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+STAGES, provided there is no stall.
- Throughput: one beat per cycle while out_ready stays high.
- Reset:
  - All stage valid bits, out_valid, sum, cout and ovf are cleared to 0.
  - in_ready = 1 in the cycle after rst is sampled high.
- Reset mid-operation: all in-flight beats are discarded. No result from before reset may appear afterwards.
- Simultaneous accept and deliver in the same cycle is legal and required for full throughput.
- Stall with an empty pipe is impossible, because out_valid=0 forces stall=0.
- The result must stay stable while out_valid && !out_ready, for any number of cycles.
- STAGES=1: degenerates to a single registered adder with latency 1.

## Configuration
- PIPE_ADDER_SUB_EN defined:
  - The sub port exists and is carried down the pipe with its beat.
  - sub=1 computes x + ~y + 1, and cin is ignored.
  - cout=1 means no borrow. ovf uses y'=~y.
- PIPE_ADDER_SUB_EN undefined:
  - The sub port is absent and the block is add-only: x + y + cin.
  - There is no inversion logic.

## Structure
- Package pipe_adder_pkg:
  - default WIDTH/STAGES constants.
  - function computing CHUNK.
  - stage-payload struct: valid, carry, remaining x/y slices, completed sum slices, sub flag.
- Sub-module pipe_adder_stage:
  - one CHUNK-wide registered slice adder with carry in/out.
  - ports for hold (stall) and synchronous reset.
  - instantiated STAGES times in a generate loop.
- Top level: handshake/stall logic, skew registers and the ovf/cout output stage.

## Test plan
(WIDTH=16, STAGES=4 unless noted.)
- x=0x00FF, y=0x0001, cin=0, out_ready=1 -> 4 cycles later sum=0x0100, cout=0, ovf=0.
- x=0xFFFF, y=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; the carry ripples across all 4 stages.
- x=0x7FFF, y=0x0001, cin=1 -> sum=0x8001, cout=0, ovf=1.
- 6 back-to-back beats (x=1..6, y=0x10); out_ready low for 3 cycles after the 2nd result:
  - in_ready drops while stalled, and results hold stable.
  - Results 0x11..0x16 arrive in order, with none lost or duplicated.
- rst pulsed for 1 cycle with 3 beats in flight -> out_valid=0 and sum=0 next cycle; the first post-reset result is only the new beat.
- With PIPE_ADDER_SUB_EN: x=0x0005, y=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Also check x=0x8000, y=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
